i2c_slave_regport: RTL and testbench
====================================

// Module: i2c_slave_regport
// PURPOSE
//  I2C target (slave) that answers one fixed 7-bit address and bridges bus traffic to a byte-wide
//  local register port. It is the far-end counterpart of the AXI-lite controlled I2C master: it
//  receives that master's START/address/data sequences, ACKs them, writes and reads local registers
//  through an auto-incrementing pointer, and drives SDA open-drain. No clock stretching.
// PARAMETERS
//  SLAVE_ADDR      7'h50  7-bit bus address answered
//  REG_ADDR_WIDTH  4      local pointer width; 2**REG_ADDR_WIDTH registers; pointer wraps
// PORTS
//  clk           in   1     system clock; must be >= 16x SCL frequency
//  arst_i        in   1     asynchronous reset, active high
//  scl_pad_i     in   1     SCL line input (asynchronous)
//  sda_pad_i     in   1     SDA line input (asynchronous)
//  sda_pad_o     out  1     SDA output value, constant 1'b0
//  sda_padoen_o  out  1     SDA output enable, active low (0 = pull SDA low)
//  wr_stb_o      out  1     one-clk write strobe to local registers
//  rd_stb_o      out  1     one-clk read request; rdata_i is sampled on the next clk
//  reg_addr_o    out  RAW   register address = current pointer, RAW = REG_ADDR_WIDTH
//  wdata_o       out  8     write data, valid with wr_stb_o
//  rdata_i       in   8     read data, valid 1 clk after rd_stb_o
//  busy_o        out  1     high from address match until STOP or non-matching address
// BEHAVIOUR
//  Reset values: sda_padoen_o=1, wr_stb_o=0, rd_stb_o=0, busy_o=0, pointer=0, wdata_o=0, state IDLE.
//  Input sampling
//  - scl_pad_i and sda_pad_i each pass through a 2-flop synchronizer. Edge detect compares the
//    synced value with its 1-clk-delayed copy.
//  - START = synced SDA falls while synced SCL is high (checked in the same clk).
//  - STOP = synced SDA rises while synced SCL is high.
//  - Input bits are sampled on the SCL rising edge. sda_padoen_o changes only in the clk after an
//    SCL falling edge.
//  Bit counting and byte states
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP.
//  - START from any state goes to ADDR, resets the bit counter and releases SDA. The pointer is
//    kept, so a repeated START is supported.
//  - STOP from any state goes to IDLE, releases SDA and sets busy_o=0.
//  Address byte
//  - ADDR shifts 8 bits, MSB first; bit 0 is R/W.
//  - Match on {addr[7:1]==SLAVE_ADDR}: busy_o=1, go to ADDR_ACK. SDA is pulled low from the next
//    SCL fall to the following SCL fall (the 9th clock).
//  - Mismatch: busy_o=0, go to WAIT_STOP with SDA released. Only START or STOP leaves WAIT_STOP.
//  - Read (R/W=1): rd_stb_o pulses on the ACK-bit SCL rise. rdata_i is loaded into the shift
//    register, and its MSB is driven on the SCL fall ending the ACK.
//  Write
//  - The first byte after address+W is the pointer; it loads pointer[RAW-1:0] and upper bits are
//    ignored (PTR, then PTR_ACK).
//  - Each later byte (WDATA): on the 8th SCL rise, wr_stb_o pulses with reg_addr_o=pointer and
//    wdata_o=byte. The pointer increments in the following clk, mod 2**RAW.
//  - Every write byte is ACKed (WDATA_ACK).
//  Read
//  - RDATA drives shift-register bits MSB first.
//    A data 1 is sent by releasing SDA (sda_padoen_o=1); a data 0 is sent by pulling SDA low
//    (sda_padoen_o=0).
//  - SDA is released after the 8th bit. The pointer increments at the 8th SCL fall.
//  - RD_MACK samples the master bit on the 9th SCL rise:
//    - 0 (ACK): rd_stb_o pulses at the new pointer and the next byte follows.
//    - 1 (NACK): go to WAIT_STOP with SDA released.
//  Boundaries
//  - Pointer wraps from 2**RAW-1 to 0 in both directions.
//  - A STOP or START in mid-byte aborts the byte: no wr_stb_o, pointer unchanged.
//  - Reset asserted mid-transfer releases SDA within the same clk (asynchronous).
//  - wr_stb_o and rd_stb_o are never high in the same clk.
// TESTING
//  - Write: START, 0xA0, 0x03, 0xA5, 0x5A, STOP.
//    -> ACK on all 4 bytes; wr_stb_o with (3,A5) then (4,5A); pointer=5; busy_o low after STOP.
//  - Read: START, 0xA0, 0x02, rep-START, 0xA1; rdata_i model returns 0x10+addr; master ACK, NACK.
//    -> SDA carries 0x12 then 0x13; rd_stb_o at addr 2, 3; SDA released after NACK.
//  - Mismatch: START, 0xA2, then 0xFF.
//    -> SDA never pulled low; no strobes; busy_o stays 0.
//  - Wrap: pointer 0x0F, write 0x11, 0x22.
//    -> wr_stb_o at addr 0x0F, then 0x00.
//  - Abort: STOP after 4 bits of a data byte.
//    -> no wr_stb_o; next transaction works normally.
//  - Reset: assert arst_i while the slave drives a 0 bit in a read.
//    -> sda_padoen_o=1 immediately, busy_o=0, pointer=0.

Source files
------------

// File: rtl/i2c_slave_regport_if.sv
// Local register port of the I2C target: strobes, pointer address and data.
// slave = the I2C target side, master = the register file side.
interface i2c_slave_regport_if #(
  parameter int RAW = 4
);
  logic           wr_stb_o;
  logic           rd_stb_o;
  logic [RAW-1:0] reg_addr_o;
  logic [7:0]     wdata_o;
  logic [7:0]     rdata_i;

  modport slave (
    output wr_stb_o,
    output rd_stb_o,
    output reg_addr_o,
    output wdata_o,
    input  rdata_i
  );

  modport master (
    input  wr_stb_o,
    input  rd_stb_o,
    input  reg_addr_o,
    input  wdata_o,
    output rdata_i
  );
endinterface

// File: rtl/i2c_slave_regport.sv
// I2C target at one fixed address, bridging bus bytes to a byte-wide
// register port through an auto-incrementing pointer; open-drain SDA.
module i2c_slave_regport #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h50,
  parameter int         REG_ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic arst_i,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic sda_pad_o,
  output logic sda_padoen_o,
  output logic busy_o,
  i2c_slave_regport_if.slave rp
);
  localparam int RAW = REG_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
  } state_t;

  state_t         state;
  logic [1:0]     scl_sync, sda_sync;
  logic           scl_d, sda_d;
  logic [3:0]     bit_cnt;
  logic [7:0]     shreg, wdata;
  logic [RAW-1:0] ptr;
  logic           rw, sda_oen, wr_stb, rd_stb, ld, busy;

  logic scl, sda, scl_rise, scl_fall;
  logic start_c, stop_c, last_bit;
  logic [7:0] byte_in;

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c  = scl & sda_d & ~sda;
  assign stop_c   = scl & ~sda_d & sda;
  assign byte_in  = {shreg[6:0], sda};
  assign last_bit = (bit_cnt == 4'd7);

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad_i};
      sda_sync <= {sda_sync[0], sda_pad_i};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wdata   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oen <= 1'b1;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      ld      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      ld     <= rd_stb;
      // read data arrives one clk after the request
      if (ld) shreg <= rp.rdata_i;
      if (wr_stb) ptr <= ptr + RAW'(1);
      if (start_c) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oen <= 1'b1;
      end else if (stop_c) begin
        state   <= IDLE;
        sda_oen <= 1'b1;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            if (last_bit) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                busy  <= 1'b1;
                rw    <= byte_in[0];
                state <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          // sda_oen doubles as the "ACK already driven" marker
          ADDR_ACK: begin
            if (scl_fall) begin
              if (sda_oen) begin
                sda_oen <= 1'b0;
              end else begin
                sda_oen <= 1'b1;
                state   <= PTR;
              end
            end else if (scl_rise && !sda_oen && rw) begin
              rd_stb  <= 1'b1;
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end
          PTR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            if (last_bit) begin
              ptr   <= byte_in[RAW-1:0];
              state <= PTR_ACK;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (sda_oen) begin
              sda_oen <= 1'b0;
            end else begin
              sda_oen <= 1'b1;
              state   <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            if (last_bit) begin
              wr_stb <= 1'b1;
              wdata  <= byte_in;
              state  <= WDATA_ACK;
            end
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oen <= 1'b1;
              ptr     <= ptr + RAW'(1);
              state   <= RD_MACK;
            end else begin
              sda_oen <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_MACK: if (scl_rise) begin
            if (!sda) begin
              rd_stb  <= 1'b1;
              bit_cnt <= '0;
              state   <= RDATA;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_pad_o     = 1'b0;
  assign sda_padoen_o  = sda_oen;
  assign busy_o        = busy;
  assign rp.wr_stb_o   = wr_stb;
  assign rp.rd_stb_o   = rd_stb;
  assign rp.reg_addr_o = ptr;
  assign rp.wdata_o    = wdata;
endmodule

// File: tb/tb_i2c_slave_regport.sv
// Bench for i2c_slave_regport: bit-level I2C master, register file
// and a transaction-level model of pointer and register contents.
module tb_i2c_slave_regport;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_o, sda_oen, busy;
  wire  sda_line = m_sda & (sda_oen | sda_o);

  always #5 clk = ~clk;

  i2c_slave_regport_if #(.RAW(4)) rp ();

  i2c_slave_regport #(.SLAVE_ADDR(7'h50), .REG_ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .arst_i       (arst),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_o),
    .sda_padoen_o (sda_oen),
    .busy_o       (busy),
    .rp           (rp)
  );

  logic [7:0]  mem [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  int          low_cnt = 0;
  int          both_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [3:0]  exp_ptr;
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];

  // register file: registered read data, one clk after rd_stb
  always @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
    end else begin
      if (rp.wr_stb_o) begin
        mem[rp.reg_addr_o] <= rp.wdata_o;
        wr_q.push_back({rp.reg_addr_o, rp.wdata_o});
      end
      if (rp.rd_stb_o) begin
        rp.rdata_i <= mem[rp.reg_addr_o];
        rd_q.push_back(rp.reg_addr_o);
      end
      if (rp.wr_stb_o && rp.rd_stb_o) both_cnt++;
      if (!sda_oen) low_cnt++;
    end
  end

  task automatic qw();
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qw();
    scl = 1'b1; qw();
    m_sda = 1'b0; qw();
    scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qw();
    scl = 1'b1; qw();
    m_sda = 1'b1; qw();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; qw();
    scl = 1'b1; qw(); qw();
    scl = 1'b0; qw();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; qw();
    scl = 1'b1; qw();
    b = sda_line; qw();
    scl = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack);
  endtask

  task automatic xfer_write(input logic [3:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(8'hA0, a); nacks += int'(a);
    write_byte({4'($urandom), p}, a); nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a); nacks += int'(a);
      ref_mem[4'(int'(p) + i)] = wbuf[i];
    end
    i2c_stop();
    exp_ptr = 4'(int'(p) + n);
  endtask

  task automatic xfer_read(input logic [3:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(8'hA0, a); nacks += int'(a);
    write_byte({4'h0, p}, a); nacks += int'(a);
    i2c_start();
    write_byte(8'hA1, a); nacks += int'(a);
    for (int i = 0; i < n; i++) read_byte(i == n - 1, rbuf[i]);
    i2c_stop();
    exp_ptr = 4'(int'(p) + n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (sda_oen !== 1'b1) $display("FAIL reset_oen: got %b want 1", sda_oen);
    else pass_cnt++;
    total_cnt++;
    if ({rp.wr_stb_o, rp.rd_stb_o, busy} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {rp.wr_stb_o, rp.rd_stb_o, busy});
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== 4'h0) $display("FAIL reset_ptr: got %h want 0", rp.reg_addr_o);
    else pass_cnt++;
    total_cnt++;
    if (rp.wdata_o !== 8'h00) $display("FAIL reset_wdata: got %h want 00", rp.wdata_o);
    else pass_cnt++;
    arst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h10 + 8'(i);
    exp_ptr = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    int r0 = rd_q.size();
    int w0 = wr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h02, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL read_busy: got %b want 1", busy);
    else pass_cnt++;
    read_byte(1'b0, rbuf[0]);
    read_byte(1'b1, rbuf[1]);
    total_cnt++;
    if (sda_oen !== 1'b1) $display("FAIL read_release: got %b want 1", sda_oen);
    else pass_cnt++;
    i2c_stop();
    exp_ptr = 4'h4;
    total_cnt++;
    if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks: got %b want 000", {a0, a1, a2});
    else pass_cnt++;
    total_cnt++;
    if (rbuf[0] !== ref_mem[2]) $display("FAIL read_d0: got %h want %h", rbuf[0], ref_mem[2]);
    else pass_cnt++;
    total_cnt++;
    if (rbuf[1] !== ref_mem[3]) $display("FAIL read_d1: got %h want %h", rbuf[1], ref_mem[3]);
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() - r0 !== 2) $display("FAIL read_nstb: got %0d want 2", rd_q.size() - r0);
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() >= r0 + 2 && {rd_q[r0], rd_q[r0+1]} !== 8'h23)
      $display("FAIL read_stb_addr: got %h want 23", {rd_q[r0], rd_q[r0+1]});
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() !== w0) $display("FAIL read_no_wr: got %0d want %0d", wr_q.size(), w0);
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== exp_ptr) $display("FAIL read_ptr: got %h want %h", rp.reg_addr_o, exp_ptr);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL read_busy_end: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int w0 = wr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    write_byte(8'hA5, a2);
    write_byte(8'h5A, a3);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL write_busy: got %b want 1", busy);
    else pass_cnt++;
    i2c_stop();
    ref_mem[3] = 8'hA5;
    ref_mem[4] = 8'h5A;
    exp_ptr = 4'h5;
    total_cnt++;
    if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL write_acks: got %b want 0000", {a0, a1, a2, a3});
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() - w0 !== 2) $display("FAIL write_nstb: got %0d want 2", wr_q.size() - w0);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() >= w0 + 2 && {wr_q[w0], wr_q[w0+1]} !== 24'h3A5_45A)
      $display("FAIL write_stb: got %h want 3a545a", {wr_q[w0], wr_q[w0+1]});
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== exp_ptr) $display("FAIL write_ptr: got %h want %h", rp.reg_addr_o, exp_ptr);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL write_busy_end: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int l0 = low_cnt;
    int w0 = wr_q.size();
    int r0 = rd_q.size();
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'hFF, a1);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL mis_busy: got %b want 0", busy);
    else pass_cnt++;
    i2c_stop();
    total_cnt++;
    if ({a0, a1} !== 2'b11) $display("FAIL mis_acks: got %b want 11", {a0, a1});
    else pass_cnt++;
    total_cnt++;
    if (low_cnt !== l0) $display("FAIL mis_sda_low: got %0d want %0d", low_cnt, l0);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() + rd_q.size() !== w0 + r0)
      $display("FAIL mis_stb: got %0d want %0d", wr_q.size() + rd_q.size(), w0 + r0);
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== exp_ptr) $display("FAIL mis_ptr: got %h want %h", rp.reg_addr_o, exp_ptr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int nk;
    int w0 = wr_q.size();
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    xfer_write(4'hF, 2, nk);
    total_cnt++;
    if (nk !== 0) $display("FAIL wrap_acks: got %0d nacks want 0", nk);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() - w0 !== 2) $display("FAIL wrap_nstb: got %0d want 2", wr_q.size() - w0);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() >= w0 + 2 && {wr_q[w0], wr_q[w0+1]} !== 24'hF11_022)
      $display("FAIL wrap_stb: got %h want f11022", {wr_q[w0], wr_q[w0+1]});
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== exp_ptr) $display("FAIL wrap_ptr: got %h want %h", rp.reg_addr_o, exp_ptr);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic a0, a1;
    int nk;
    int w0 = wr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h05, a1);
    for (int i = 0; i < 4; i++) write_bit(i < 2);
    i2c_stop();
    exp_ptr = 4'h5;
    total_cnt++;
    if (wr_q.size() !== w0) $display("FAIL abort_no_wr: got %0d want %0d", wr_q.size(), w0);
    else pass_cnt++;
    total_cnt++;
    if (rp.reg_addr_o !== exp_ptr) $display("FAIL abort_ptr: got %h want %h", rp.reg_addr_o, exp_ptr);
    else pass_cnt++;
    wbuf[0] = 8'h77;
    xfer_write(4'h5, 1, nk);
    total_cnt++;
    if (nk !== 0 || wr_q.size() !== w0 + 1) $display("FAIL abort_next: got %0d nacks %0d strobes want 0 1", nk, wr_q.size() - w0);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() > w0 && wr_q[w0] !== 12'h577) $display("FAIL abort_next_stb: got %h want 577", wr_q[w0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [3:0] p = 4'($urandom_range(0, 15));
      int n = int'($urandom_range(1, 4));
      int nk;
      int w0 = wr_q.size();
      int r0;
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      xfer_write(p, n, nk);
      total_cnt++;
      if (nk !== 0 || wr_q.size() - w0 !== n)
        $display("FAIL rnd_wr_%0d: got %0d nacks %0d strobes want 0 %0d", it, nk, wr_q.size() - w0, n);
      else pass_cnt++;
      for (int i = 0; i < n && w0 + i < wr_q.size(); i++) begin
        total_cnt++;
        if (wr_q[w0+i] !== {4'(int'(p) + i), wbuf[i]})
          $display("FAIL rnd_wstb_%0d_%0d: got %h want %h", it, i, wr_q[w0+i], {4'(int'(p) + i), wbuf[i]});
        else pass_cnt++;
      end
      r0 = rd_q.size();
      xfer_read(p, n, nk);
      total_cnt++;
      if (nk !== 0 || rd_q.size() - r0 !== n)
        $display("FAIL rnd_rd_%0d: got %0d nacks %0d strobes want 0 %0d", it, nk, rd_q.size() - r0, n);
      else pass_cnt++;
      for (int i = 0; i < n; i++) begin
        total_cnt++;
        if (rbuf[i] !== ref_mem[4'(int'(p) + i)])
          $display("FAIL rnd_rdata_%0d_%0d: got %h want %h", it, i, rbuf[i], ref_mem[4'(int'(p) + i)]);
        else pass_cnt++;
      end
      total_cnt++;
      if (rp.reg_addr_o !== exp_ptr) $display("FAIL rnd_ptr_%0d: got %h want %h", it, rp.reg_addr_o, exp_ptr);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midread();
    logic a;
    int nk;
    int w0;
    wbuf[0] = 8'h00;
    xfer_write(4'h7, 1, nk);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h07, a);
    i2c_start();
    write_byte(8'hA1, a);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (sda_oen !== 1'b0) $display("FAIL rst_pre_drive: got %b want 0", sda_oen);
    else pass_cnt++;
    arst = 1'b1;
    #1;
    total_cnt++;
    if (sda_oen !== 1'b1) $display("FAIL rst_async_oen: got %b want 1", sda_oen);
    else pass_cnt++;
    total_cnt++;
    if ({busy, rp.reg_addr_o} !== 5'h00) $display("FAIL rst_async_state: got %h want 00", {busy, rp.reg_addr_o});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h10 + 8'(i);
    exp_ptr = 4'h0;
    i2c_stop();
    w0 = wr_q.size();
    wbuf[0] = 8'h99;
    xfer_write(4'h2, 1, nk);
    total_cnt++;
    if (nk !== 0 || wr_q.size() !== w0 + 1 || wr_q[w0] !== 12'h299)
      $display("FAIL rst_after: got %0d nacks %0d strobes want 0 1", nk, wr_q.size() - w0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_mismatch();
    test_wrap();
    test_abort();
    test_random();
    test_reset_midread();
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL stb_overlap: got %0d want 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
